// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
// Parametrised UART receiver for the motor-control command path. The frame
// format (data width, parity mode, stop bits) is fixed at elaboration. Each
// bit is decided by a 3-sample majority vote taken around mid-bit.
//
// Ports:
//   i_Clock       system clock
//   i_Reset       synchronous reset, active-high
//   i_Rx_Serial   asynchronous serial line, idle high
//   o_Rx_DV       one-cycle strobe: frame complete, word and flags valid
//   o_Rx_Byte     received data word (DATA_BITS wide, sent LSB first)
//   o_Parity_Err  parity mismatch on last frame (0 when PARITY_MODE = 0)
//   o_Frame_Err   a stop bit was sampled 0 on last frame
//   o_Break       last frame was a break (all data 0, parity 0, stop 0)
//   o_Busy        receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  // Slot counter is sized exactly to the bit period.
  localparam int CW = $clog2(CLKS_PER_BIT);
  // Bit index covers data bits and stop bits.
  localparam int IW = $clog2(DATA_BITS + 32'sd1);
  // Mid-bit sample point.
  localparam int H  = (CLKS_PER_BIT - 32'sd1) / 32'sd2;
  localparam bit PB = (PARITY_MODE != 32'sd0);

  localparam logic [CW-1:0] CNT_ONE       = CW'(32'sd1);
  localparam logic [CW-1:0] CNT_LAST      = CW'(CLKS_PER_BIT - 32'sd1);
  localparam logic [CW-1:0] CNT_SMP_A     = CW'(H - 32'sd1);
  localparam logic [CW-1:0] CNT_SMP_B     = CW'(H);
  localparam logic [CW-1:0] CNT_DEC       = CW'(H + 32'sd1);
  localparam logic [IW-1:0] IDX_ONE       = IW'(32'sd1);
  localparam logic [IW-1:0] IDX_DATA_LAST = IW'(DATA_BITS - 32'sd1);
  localparam logic [IW-1:0] IDX_STOP_LAST = IW'(STOP_BITS - 32'sd1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } state_t;

  // Majority of three samples.
  function automatic logic maj3_f(input logic a, input logic b, input logic c);
    maj3_f = (a & b) | (a & c) | (b & c);
  endfunction

  // Parity check of the received word against the received parity bit.
  function automatic logic parity_err_f(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    if (PARITY_MODE == 32'sd1) begin
      parity_err_f = (x != 1'b1);
    end else if (PARITY_MODE == 32'sd2) begin
      parity_err_f = (x != 1'b0);
    end else begin
      parity_err_f = 1'b0;
    end
  endfunction

  logic                 rx_meta_r;
  logic                 rx_sync_r;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_nxt_s;
  logic [IW-1:0]        idx_r;
  logic [IW-1:0]        idx_nxt_s;
  logic [DATA_BITS-1:0] shreg_r;
  logic [DATA_BITS-1:0] shreg_nxt_s;
  logic                 smp_a_r;
  logic                 smp_a_nxt_s;
  logic                 smp_b_r;
  logic                 smp_b_nxt_s;
  logic                 par_bit_r;
  logic                 par_bit_nxt_s;
  logic                 par_err_r;
  logic                 par_err_nxt_s;
  logic                 stop_any0_r;
  logic                 stop_any0_nxt_s;
  logic                 stop_all0_r;
  logic                 stop_all0_nxt_s;

  logic                 maj_s;
  logic                 at_dec_s;
  logic                 slot_end_s;
  logic                 stop_any0_now_s;
  logic                 stop_all0_now_s;
  logic                 done_s;
  logic                 frame_err_s;
  logic                 brk_s;

  // Third sample is the live synchronised line at the decision count.
  assign maj_s           = maj3_f(smp_a_r, smp_b_r, rx_sync_r);
  assign at_dec_s        = (cnt_r == CNT_DEC);
  assign slot_end_s      = (cnt_r == CNT_LAST);
  // Stop-bit history including the slot being decided now.
  assign stop_any0_now_s = stop_any0_r | ~maj_s;
  assign stop_all0_now_s = stop_all0_r & ~maj_s;

  // Two-flop synchroniser on the asynchronous serial line; resets to idle-high.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= i_Rx_Serial;
      rx_sync_r <= rx_meta_r;
    end
  end

  // FSM state and receive datapath registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      idx_r       <= '0;
      shreg_r     <= '0;
      smp_a_r     <= 1'b1;
      smp_b_r     <= 1'b1;
      par_bit_r   <= 1'b0;
      par_err_r   <= 1'b0;
      stop_any0_r <= 1'b0;
      stop_all0_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      idx_r       <= idx_nxt_s;
      shreg_r     <= shreg_nxt_s;
      smp_a_r     <= smp_a_nxt_s;
      smp_b_r     <= smp_b_nxt_s;
      par_bit_r   <= par_bit_nxt_s;
      par_err_r   <= par_err_nxt_s;
      stop_any0_r <= stop_any0_nxt_s;
      stop_all0_r <= stop_all0_nxt_s;
    end
  end

  // Next-state, slot timing, sampling and frame decisions.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    idx_nxt_s       = idx_r;
    shreg_nxt_s     = shreg_r;
    smp_a_nxt_s     = smp_a_r;
    smp_b_nxt_s     = smp_b_r;
    par_bit_nxt_s   = par_bit_r;
    par_err_nxt_s   = par_err_r;
    stop_any0_nxt_s = stop_any0_r;
    stop_all0_nxt_s = stop_all0_r;
    done_s          = 1'b0;
    frame_err_s     = 1'b0;
    brk_s           = 1'b0;

    // Early samples of the vote; the counter never reaches these in IDLE.
    if (cnt_r == CNT_SMP_A) begin
      smp_a_nxt_s = rx_sync_r;
    end else begin
      smp_a_nxt_s = smp_a_r;
    end
    if (cnt_r == CNT_SMP_B) begin
      smp_b_nxt_s = rx_sync_r;
    end else begin
      smp_b_nxt_s = smp_b_r;
    end

    // Free-running slot counter; states that must hold it override below.
    if (slot_end_s) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end

    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s       = '0;
        idx_nxt_s       = '0;
        par_bit_nxt_s   = 1'b0;
        par_err_nxt_s   = 1'b0;
        stop_any0_nxt_s = 1'b0;
        stop_all0_nxt_s = 1'b1;
        if (!rx_sync_r) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_START: begin
        // A start bit that votes high is a glitch: drop it silently.
        if (at_dec_s && maj_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end else if (slot_end_s) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_START;
        end
      end

      ST_DATA: begin
        if (at_dec_s) begin
          shreg_nxt_s = {maj_s, shreg_r[DATA_BITS-1:1]};
        end else begin
          shreg_nxt_s = shreg_r;
        end
        if (slot_end_s) begin
          if (idx_r == IDX_DATA_LAST) begin
            idx_nxt_s   = '0;
            state_nxt_s = PB ? ST_PARITY : ST_STOP;
          end else begin
            idx_nxt_s   = idx_r + IDX_ONE;
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (at_dec_s) begin
          par_bit_nxt_s = maj_s;
          par_err_nxt_s = parity_err_f(shreg_r, maj_s);
        end else begin
          par_bit_nxt_s = par_bit_r;
          par_err_nxt_s = par_err_r;
        end
        if (slot_end_s) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end

      ST_STOP: begin
        if (at_dec_s) begin
          if (idx_r == IDX_STOP_LAST) begin
            // Deliver at mid final stop bit so the next start edge is not missed.
            done_s      = 1'b1;
            frame_err_s = stop_any0_now_s;
            brk_s       = stop_all0_now_s & (shreg_r == '0) & ~par_bit_r;
            cnt_nxt_s   = '0;
            idx_nxt_s   = '0;
            if (stop_any0_now_s) begin
              state_nxt_s = ST_BRK_WAIT;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            stop_any0_nxt_s = stop_any0_now_s;
            stop_all0_nxt_s = stop_all0_now_s;
            state_nxt_s     = ST_STOP;
          end
        end else if (slot_end_s) begin
          idx_nxt_s   = idx_r + IDX_ONE;
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end

      ST_BRK_WAIT: begin
        // A low line must return high before a new start can be armed.
        cnt_nxt_s = '0;
        if (rx_sync_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BRK_WAIT;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
        idx_nxt_s   = '0;
      end
    endcase
  end

  // Output register: word and flags load with the strobe and hold until the next one.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      // Registered from next state so it tracks the state register exactly.
      o_Busy <= (state_nxt_s != ST_IDLE);
      if (done_s) begin
        o_Rx_DV      <= 1'b1;
        o_Rx_Byte    <= shreg_r;
        o_Parity_Err <= par_err_r;
        o_Frame_Err  <= frame_err_s;
        o_Break      <= brk_s;
      end else begin
        o_Rx_DV <= 1'b0;
      end
    end
  end

endmodule
